// File: rtl/hash_search_ctrl_if.sv
// hash_search_ctrl_if: request/result handshake between the nonce-search sequencer and the hash core.
// Latency: none; these are plain wires.
// Backpressure: none on the bus itself; the sequencer keeps one request outstanding until hash_done.
//
// Signals:
//   hash_req     one-cycle request from the sequencer
//   hash_bloque  {payload, nonce}, held stable by the sequencer from hash_req until hash_done
//   hash_done    single-cycle result-valid pulse from the core
//   hash_result  24-bit core output, valid with hash_done
interface hash_search_ctrl_if #(
  parameter int NONCE_W = 32
);
  logic                    hash_req;
  logic [96+NONCE_W-1:0]   hash_bloque;
  logic                    hash_done;
  logic [23:0]             hash_result;

  modport master (
    output hash_req,
    output hash_bloque,
    input  hash_done,
    input  hash_result
  );

  modport slave (
    input  hash_req,
    input  hash_bloque,
    output hash_done,
    output hash_result
  );
endinterface

// File: rtl/hash_search_ctrl.sv
// hash_search_ctrl: nonce-search sequencer feeding one {payload,nonce} bloque per attempt to the hash core.
// Latency: 3 cycles + core latency per attempt (ISSUE, WAIT >= 1, CHECK), plus one DONE cycle at the end.
// Backpressure: one request outstanding; the next nonce is issued only after hash_done (or a timeout).
//
// Ports:
//   clk, active          clock and asynchronous active-low reset
//   start, abort         start is sampled in IDLE only; abort is honoured in every busy state but DONE
//   payload, target      search parameters, latched on an accepted start
//   nonce_first/last     inclusive nonce range, may wrap through zero
//   hif (master)         hash core handshake: hash_req/hash_bloque out, hash_done/hash_result in
//   busy, terminado      search in progress / one-cycle end-of-search pulse
//   found, nonceOut,     outcome of the last search, held until the next accepted start
//   hashOut, status,     (status: 0 found, 1 exhausted, 2 aborted, 3 core timeout)
//   attempts
module hash_search_ctrl #(
  parameter int NONCE_W = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               active,
  input  logic               start,
  input  logic               abort,
  input  logic [95:0]        payload,
  input  logic [7:0]         target,
  input  logic [NONCE_W-1:0] nonce_first,
  input  logic [NONCE_W-1:0] nonce_last,
  hash_search_ctrl_if.master hif,
  output logic               busy,
  output logic               terminado,
  output logic               found,
  output logic [NONCE_W-1:0] nonceOut,
  output logic [23:0]        hashOut,
  output logic [1:0]         status,
  output logic [31:0]        attempts
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // Last WAIT cycle in which a done is still accepted; the next cycle is DONE,
  // which puts terminado exactly TIMEOUT+1 cycles after hash_req.
  localparam logic [TW-1:0]      TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]      TIMER_ONE = TW'(1);
  localparam logic [NONCE_W-1:0] NONCE_ONE = NONCE_W'(1);

  localparam logic [1:0] ST_FOUND   = 2'd0;
  localparam logic [1:0] ST_EXHAUST = 2'd1;
  localparam logic [1:0] ST_ABORT   = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [95:0]        payload_q;
  logic [7:0]         target_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] nonce_last_q;
  logic [23:0]        res_q;
  logic [TW-1:0]      timer_q;

  logic       do_latch;
  logic       do_capture;
  logic       do_hit;
  logic       do_step;
  logic       do_end;
  logic [1:0] end_status;
  logic       hit_valid;

  // Both low bytes must be strictly below the difficulty byte; bits 23:16 do not take part.
  assign hit_valid = (res_q[7:0] < target_q) && (res_q[15:8] < target_q);

  always_ff @(posedge clk or negedge active) begin
    if (!active) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    do_latch        = 1'b0;
    do_capture      = 1'b0;
    do_hit          = 1'b0;
    do_step         = 1'b0;
    do_end          = 1'b0;
    end_status      = ST_FOUND;
    busy            = (state_q != S_IDLE);
    terminado       = (state_q == S_DONE);
    hif.hash_req    = (state_q == S_ISSUE);
    hif.hash_bloque = {payload_q, nonce_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          do_latch = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          do_end     = 1'b1;
          end_status = ST_ABORT;
          state_d    = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // abort wins over a coincident done, so that result is neither counted nor checked
        if (abort) begin
          do_end     = 1'b1;
          end_status = ST_ABORT;
          state_d    = S_DONE;
        end else if (hif.hash_done) begin
          do_capture = 1'b1;
          state_d    = S_CHECK;
        end else if (timer_q == TMO_LAST) begin
          do_end     = 1'b1;
          end_status = ST_TIMEOUT;
          state_d    = S_DONE;
        end
      end
      S_CHECK: begin
        if (abort) begin
          do_end     = 1'b1;
          end_status = ST_ABORT;
          state_d    = S_DONE;
        end else if (hit_valid) begin
          do_hit  = 1'b1;
          state_d = S_DONE;
        end else if (nonce_q == nonce_last_q) begin
          do_end     = 1'b1;
          end_status = ST_EXHAUST;
          state_d    = S_DONE;
        end else begin
          do_step = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge active) begin
    if (!active) begin
      payload_q    <= '0;
      target_q     <= '0;
      nonce_q      <= '0;
      nonce_last_q <= '0;
      res_q        <= '0;
      timer_q      <= '0;
      found        <= 1'b0;
      nonceOut     <= '0;
      hashOut      <= '0;
      status       <= ST_FOUND;
      attempts     <= '0;
    end else begin
      if (state_q == S_ISSUE) begin
        timer_q <= '0;
      end else if (state_q == S_WAIT) begin
        timer_q <= timer_q + TIMER_ONE;
      end

      // nonceOut/hashOut keep the previous winner; found=0 marks them stale.
      if (do_latch) begin
        payload_q    <= payload;
        target_q     <= target;
        nonce_q      <= nonce_first;
        nonce_last_q <= nonce_last;
        found        <= 1'b0;
        status       <= ST_FOUND;
        attempts     <= '0;
      end

      if (do_capture) begin
        res_q <= hif.hash_result;
        if (attempts != '1) begin
          attempts <= attempts + 32'd1;
        end
      end

      if (do_hit) begin
        found    <= 1'b1;
        nonceOut <= nonce_q;
        hashOut  <= res_q;
        status   <= ST_FOUND;
      end

      if (do_end) begin
        status <= end_status;
      end

      // Natural modulo-2^NONCE_W wrap lets a range with last < first run through zero.
      if (do_step) begin
        nonce_q <= nonce_q + NONCE_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hash_search_ctrl.sv
// tb_hash_search_ctrl: directed and randomized checks of the nonce-search sequencer
// against a hash-core model and a search-level reference model.
module tb_hash_search_ctrl;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        active;
  logic        start;
  logic        abort;
  logic [95:0] payload;
  logic [7:0]  target;
  logic [31:0] nonce_first;
  logic [31:0] nonce_last;
  logic        busy;
  logic        terminado;
  logic        found;
  logic [31:0] nonceOut;
  logic [23:0] hashOut;
  logic [1:0]  status;
  logic [31:0] attempts;

  hash_search_ctrl_if #(.NONCE_W(32)) hif();

  hash_search_ctrl #(.NONCE_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .active      (active),
    .start       (start),
    .abort       (abort),
    .payload     (payload),
    .target      (target),
    .nonce_first (nonce_first),
    .nonce_last  (nonce_last),
    .hif         (hif),
    .busy        (busy),
    .terminado   (terminado),
    .found       (found),
    .nonceOut    (nonceOut),
    .hashOut     (hashOut),
    .status      (status),
    .attempts    (attempts)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // hash core model configuration
  bit          core_en;
  int          core_lat;
  bit          res_mode;   // 0: single hit nonce, 1: pseudo-random hash
  logic [31:0] hit_nonce;
  logic [23:0] hit_res;
  logic [31:0] seed;
  logic [127:0] got_q[$];
  int unsigned req_cyc;

  // reference model results
  logic [31:0] exp_q[$];
  bit          e_found;
  logic [31:0] e_nonce;
  logic [23:0] e_hash;
  logic [1:0]  e_status;
  int          e_att;

  // observations of one search
  bit          o_found;
  logic [31:0] o_nonce;
  logic [23:0] o_hash;
  logic [1:0]  o_status;
  logic [31:0] o_att;
  logic        o_busy_after;
  logic        o_term_after;

  function automatic logic [23:0] res_of(input logic [31:0] n);
    logic [31:0] m;
    if (res_mode == 1'b0) begin
      if (n == hit_nonce) return hit_res;
      return 24'hffffff;
    end
    m = (n ^ seed) * 32'h9e3779b1;
    m = m ^ (m >> 15);
    return m[23:0];
  endfunction

  // Hash core: records every request, answers core_lat cycles later when enabled.
  initial begin
    hif.hash_done   = 1'b0;
    hif.hash_result = '0;
    forever begin
      @(posedge clk); #1;
      if (active === 1'b1 && hif.hash_req === 1'b1) begin
        got_q.push_back(hif.hash_bloque);
        req_cyc = cyc;
        if (core_en) begin
          repeat (core_lat) @(posedge clk);
          #1;
          hif.hash_done   = 1'b1;
          hif.hash_result = res_of(hif.hash_bloque[31:0]);
          @(posedge clk); #1;
          hif.hash_done   = 1'b0;
        end
      end
    end
  end

  // Walks the nonce range exactly as a search is defined: try, test, stop on hit or at last.
  task automatic model(input logic [31:0] f, input logic [31:0] l, input logic [7:0] tg);
    logic [31:0] n;
    logic [23:0] r;
    bit          stop;
    exp_q.delete();
    e_found  = 1'b0;
    e_nonce  = '0;
    e_hash   = '0;
    e_status = 2'd1;
    n        = f;
    stop     = 1'b0;
    for (int k = 0; k < 4096 && !stop; k++) begin
      exp_q.push_back(n);
      r = res_of(n);
      if (r[7:0] < tg && r[15:8] < tg) begin
        e_found  = 1'b1;
        e_nonce  = n;
        e_hash   = r;
        e_status = 2'd0;
        stop     = 1'b1;
      end else if (n == l) begin
        stop = 1'b1;
      end else begin
        n = n + 32'd1;
      end
    end
    e_att = exp_q.size();
  endtask

  task automatic pulse_start(input logic [95:0] pl, input logic [7:0] tg,
                             input logic [31:0] f, input logic [31:0] l);
    got_q.delete();
    payload     = pl;
    target      = tg;
    nonce_first = f;
    nonce_last  = l;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  task automatic wait_term(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(posedge clk); #1;
      if (terminado === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic do_search(input logic [95:0] pl, input logic [7:0] tg,
                           input logic [31:0] f, input logic [31:0] l, output bit ok);
    pulse_start(pl, tg, f, l);
    wait_term(ok);
    o_found  = found;
    o_nonce  = nonceOut;
    o_hash   = hashOut;
    o_status = status;
    o_att    = attempts;
    @(posedge clk); #1;
    o_busy_after = busy;
    o_term_after = terminado;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({hif.hash_req, busy, terminado, found, status} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req/busy/term/found/status=%b exp 00000",
               {hif.hash_req, busy, terminado, found, status});
    end
    n_checks++;
    if (hif.hash_bloque !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_bloque: got %h exp 0", hif.hash_bloque);
    end
    n_checks++;
    if ({nonceOut, hashOut, attempts} !== 88'h0) begin
      n_fail++;
      $display("FAIL reset_results: got %h %h %h exp 0", nonceOut, hashOut, attempts);
    end
    active = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: got %b exp 0", busy);
    end
  endtask

  task automatic test_first_hit();
    logic [95:0] p;
    bit ok;
    p = 96'hdeadbeef_01234567_89abcdef;
    res_mode = 1'b0; hit_nonce = 32'd3; hit_res = 24'h000505; core_lat = 2;
    do_search(p, 8'h10, 32'd0, 32'd9, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL hit_term: got none exp terminado"); end
    n_checks++;
    if ({o_found, o_status} !== 3'b100) begin
      n_fail++; $display("FAIL hit_found_status: got %b/%0d exp 1/0", o_found, o_status);
    end
    n_checks++;
    if (o_nonce !== 32'd3 || o_hash !== 24'h000505) begin
      n_fail++; $display("FAIL hit_outputs: got %h/%h exp 3/000505", o_nonce, o_hash);
    end
    n_checks++;
    if (o_att !== 32'd4) begin n_fail++; $display("FAIL hit_attempts: got %0d exp 4", o_att); end
    n_checks++;
    if (got_q.size() != 4 || got_q[got_q.size()-1] !== {p, 32'd3}) begin
      n_fail++; $display("FAIL hit_bloque: got %0d reqs exp 4 ending {P,3}", got_q.size());
    end
    n_checks++;
    if (o_busy_after !== 1'b0 || o_term_after !== 1'b0) begin
      n_fail++; $display("FAIL hit_after: got busy=%b term=%b exp 0/0", o_busy_after, o_term_after);
    end
  endtask

  task automatic test_exhaustion();
    bit ok;
    res_mode = 1'b0; hit_nonce = 32'd6; hit_res = 24'h000000; core_lat = 1;
    do_search(96'h1, 8'h00, 32'd5, 32'd7, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL exh_term: got none exp terminado"); end
    n_checks++;
    if (got_q.size() != 3) begin n_fail++; $display("FAIL exh_reqs: got %0d exp 3", got_q.size()); end
    n_checks++;
    if ({o_found, o_status} !== 3'b001) begin
      n_fail++; $display("FAIL exh_status: got %b/%0d exp 0/1", o_found, o_status);
    end
    n_checks++;
    if (o_att !== 32'd3) begin n_fail++; $display("FAIL exh_attempts: got %0d exp 3", o_att); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w[4];
    bit ok;
    int bad;
    exp_w = '{32'hfffffffe, 32'hffffffff, 32'h00000000, 32'h00000001};
    res_mode = 1'b0; hit_nonce = 32'h12345; hit_res = 24'h0; core_lat = 3;
    do_search(96'h55, 8'hff, 32'hfffffffe, 32'h00000001, ok);
    n_checks++;
    if (!ok || o_status !== 2'd1 || o_att !== 32'd4) begin
      n_fail++; $display("FAIL wrap_status: got term=%b status=%0d att=%0d exp 1/1/4", ok, o_status, o_att);
    end
    bad = (got_q.size() != 4) ? 1 : 0;
    for (int i = 0; i < 4 && bad == 0; i++) begin
      if (got_q[i][31:0] !== exp_w[i]) bad = 1;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL wrap_nonces: got %0d reqs exp 4 as fffffffe,ffffffff,0,1", got_q.size());
    end
  endtask

  task automatic test_boundary();
    logic [23:0] bres[5];
    bit          bval[5];
    bit ok;
    bres = '{24'h001010, 24'h000f0f, 24'h00100f, 24'h000f10, 24'hff0000};
    bval = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    res_mode = 1'b0; hit_nonce = 32'h40; core_lat = 1;
    for (int i = 0; i < 5; i++) begin
      hit_res = bres[i];
      do_search(96'h77, 8'h10, 32'h40, 32'h40, ok);
      n_checks++;
      if (!ok || o_found !== bval[i] || o_status !== (bval[i] ? 2'd0 : 2'd1) || o_att !== 32'd1) begin
        n_fail++;
        $display("FAIL boundary_%h: got term=%b found=%b status=%0d att=%0d exp found=%b att=1",
                 bres[i], ok, o_found, o_status, o_att, bval[i]);
      end
      if (bval[i]) begin
        n_checks++;
        if (o_hash !== bres[i] || o_nonce !== 32'h40) begin
          n_fail++; $display("FAIL boundary_out: got %h/%h exp %h/40", o_hash, o_nonce, bres[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int unsigned delta;
    core_en = 1'b0;
    pulse_start(96'h99, 8'h10, 32'd20, 32'd30);
    wait_term(ok);
    delta = cyc - req_cyc;
    n_checks++;
    if (!ok || delta != TIMEOUT + 1) begin
      n_fail++; $display("FAIL timeout_delay: got term=%b after %0d cycles exp %0d", ok, delta, TIMEOUT + 1);
    end
    n_checks++;
    if (status !== 2'd3 || found !== 1'b0 || attempts !== 32'd0 || got_q.size() != 1) begin
      n_fail++; $display("FAIL timeout_status: got status=%0d found=%b att=%0d reqs=%0d exp 3/0/0/1",
                         status, found, attempts, got_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
    core_en = 1'b1;
  endtask

  task automatic test_abort();
    // abort in WAIT with the core silent, plus an ignored start while busy
    core_en = 1'b0;
    pulse_start(96'habc, 8'h80, 32'd100, 32'd200);
    repeat (3) @(posedge clk);
    #1;
    nonce_first = 32'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || hif.hash_req !== 1'b0 || hif.hash_bloque[31:0] !== 32'd100) begin
      n_fail++; $display("FAIL start_ignored: got busy=%b req=%b nonce=%h exp 1/0/64",
                         busy, hif.hash_req, hif.hash_bloque[31:0]);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (terminado !== 1'b1 || status !== 2'd2 || attempts !== 32'd0) begin
      n_fail++; $display("FAIL abort_wait: got term=%b status=%0d att=%0d exp 1/2/0", terminado, status, attempts);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || terminado !== 1'b0) begin
      n_fail++; $display("FAIL abort_after: got busy=%b term=%b exp 0/0", busy, terminado);
    end
    core_en = 1'b1;

    // abort coincident with a hit-producing done: neither counted nor found
    res_mode = 1'b0; hit_nonce = 32'd50; hit_res = 24'h000000; core_lat = 1;
    pulse_start(96'hdef, 8'h10, 32'd50, 32'd60);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (terminado !== 1'b1 || status !== 2'd2 || attempts !== 32'd0 || found !== 1'b0) begin
      n_fail++; $display("FAIL abort_done: got term=%b status=%0d att=%0d found=%b exp 1/2/0/0",
                         terminado, status, attempts, found);
    end
    repeat (3) @(posedge clk);
    #1;

    // abort in CHECK beats the hit being checked
    pulse_start(96'hdef, 8'h10, 32'd50, 32'd60);
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (terminado !== 1'b1 || status !== 2'd2 || attempts !== 32'd1 || found !== 1'b0) begin
      n_fail++; $display("FAIL abort_check: got term=%b status=%0d att=%0d found=%b exp 1/2/1/0",
                         terminado, status, attempts, found);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int seen;
    core_en = 1'b0;
    pulse_start(96'h1234, 8'h10, 32'd7, 32'd9);
    repeat (2) @(posedge clk);
    #2;
    active = 1'b0;
    #1;
    n_checks++;
    if ({hif.hash_req, busy, terminado, found, status} !== 5'b0 || hif.hash_bloque !== 128'h0) begin
      n_fail++; $display("FAIL reset_mid_ctrl: got ctrl=%b bloque=%h exp 0",
                         {hif.hash_req, busy, terminado, found, status}, hif.hash_bloque);
    end
    n_checks++;
    if ({nonceOut, hashOut, attempts} !== 88'h0) begin
      n_fail++; $display("FAIL reset_mid_results: got %h %h %h exp 0", nonceOut, hashOut, attempts);
    end
    seen = 0;
    @(posedge clk); #1;
    active = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (terminado !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL reset_mid_quiet: got %0d active cycles exp 0", seen); end
    core_en = 1'b1;
  endtask

  task automatic test_random();
    logic [95:0] pl;
    logic [7:0]  tg;
    logic [31:0] f;
    logic [31:0] l;
    bit ok;
    int bad;
    res_mode = 1'b1;
    for (int it = 0; it < 25; it++) begin
      seed     = $urandom;
      core_lat = $urandom_range(1, 4);
      pl       = {$urandom, $urandom, $urandom};
      tg       = 8'($urandom_range(0, 96));
      f        = (it % 3 == 0) ? (32'hffffffff - 32'($urandom_range(0, 8))) : $urandom;
      l        = f + 32'($urandom_range(0, 15));
      model(f, l, tg);
      do_search(pl, tg, f, l, ok);
      n_checks++;
      if (!ok || o_found !== e_found || o_status !== e_status || o_att !== 32'(e_att)) begin
        n_fail++; $display("FAIL rand_%0d_outcome: got term=%b found=%b status=%0d att=%0d exp 1/%b/%0d/%0d",
                           it, ok, o_found, o_status, o_att, e_found, e_status, e_att);
      end
      if (e_found) begin
        n_checks++;
        if (o_nonce !== e_nonce || o_hash !== e_hash) begin
          n_fail++; $display("FAIL rand_%0d_winner: got %h/%h exp %h/%h", it, o_nonce, o_hash, e_nonce, e_hash);
        end
      end
      bad = (got_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < exp_q.size() && bad == 0; i++) begin
        if (got_q[i] !== {pl, exp_q[i]}) bad = 1;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL rand_%0d_bloques: got %0d reqs exp %0d or bloque differs",
                           it, got_q.size(), exp_q.size());
      end
      n_checks++;
      if (o_busy_after !== 1'b0 || o_term_after !== 1'b0) begin
        n_fail++; $display("FAIL rand_%0d_after: got busy=%b term=%b exp 0/0", it, o_busy_after, o_term_after);
      end
    end
  endtask

  initial begin
    active = 1'b0; start = 1'b0; abort = 1'b0;
    payload = '0; target = '0; nonce_first = '0; nonce_last = '0;
    core_en = 1'b1; core_lat = 1; res_mode = 1'b0;
    hit_nonce = '0; hit_res = '0; seed = '0;
    test_reset();
    test_first_hit();
    test_exhaustion();
    test_wrap();
    test_boundary();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
